// File: rtl/fpu_pack.sv
// Shared FPU definitions: real_t single-precision layout, exponent bias and
// the fixed-to-real pipeline stage record.
package fpu_pack;

  localparam int BW_EXPN      = 8;
  localparam int BW_FRAC      = 23;
  localparam int BW_DATA      = 1 + BW_EXPN + BW_FRAC;
  localparam int EXP_BASE     = 127;
  localparam int LAT_FIX2REAL = 3;

  // Widest legal fixed-point input; the S2->S3 record is sized for it.
  localparam int BW_INT_MAX   = 64;
  localparam int BW_EXPS      = BW_EXPN + 2;

  typedef struct packed {
    logic               sign;
    logic [BW_EXPN-1:0] expn;
    logic [BW_FRAC-1:0] frac;
  } real_t;

  // norm is left-justified in BW_INT_MAX bits so one record type serves
  // every BW_INT; the unused low bits are always zero.
  typedef struct packed {
    logic                      sign;
    logic                      zero;
    logic signed [BW_EXPS-1:0] expn;
    logic [BW_INT_MAX-1:0]     norm;
  } fix2real_norm_t;

  function automatic real_t pack_real(input logic sign,
                                      input logic [BW_EXPN-1:0] expn,
                                      input logic [BW_FRAC-1:0] frac);
    real_t r;
    r.sign = sign;
    r.expn = expn;
    r.frac = frac;
    return r;
  endfunction

endpackage

// File: rtl/fpu_lzc.sv
// Combinational leading-zero counter; count equals WIDTH for an all-zero
// input.
module fpu_lzc #(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CW   = $clog2(WIDTH) + 1
) (
  input  logic [WIDTH-1:0] data,
  output logic [CW-1:0]    count
);

  // Scanning upward lets the highest set bit write last and win.
  always_comb begin
    count = CW'(WIDTH);
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (data[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fpu_fix2real.sv
// Three-stage signed fixed-point to real_t converter with valid/ready
// handshake. Optional out_inexact port under `FPU_FIX2REAL_STATUS_EN.
module fpu_fix2real
  import fpu_pack::*;
#(
  parameter int BW_INT    = 32,
  parameter int FRAC_BITS = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [BW_INT-1:0]  in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [BW_DATA-1:0] out_data
`ifdef FPU_FIX2REAL_STATUS_EN
  ,
  output logic               out_inexact
`endif
);

  localparam int LZW     = $clog2(BW_INT) + 1;
  localparam int EXP_MIN = EXP_BASE - FRAC_BITS;
  localparam int EXP_MAX = EXP_BASE + BW_INT - FRAC_BITS;
  localparam int REST_W  = BW_INT_MAX - BW_FRAC - 2;
  localparam logic signed [BW_EXPS-1:0] EXP_TOP =
    BW_EXPS'(EXP_BASE + BW_INT - 1 - FRAC_BITS);

  if (BW_INT < 2 || BW_INT > BW_INT_MAX) begin : g_bad_bw_int
    $error("fpu_fix2real: BW_INT out of range 2..%0d", BW_INT_MAX);
  end
  if (FRAC_BITS < 0 || FRAC_BITS > BW_INT - 1) begin : g_bad_frac_bits
    $error("fpu_fix2real: FRAC_BITS out of range 0..BW_INT-1");
  end
  if (EXP_MIN < 1 || EXP_MAX > 254) begin : g_bad_exp_range
    $error("fpu_fix2real: exponent range leaves the normal range 1..254");
  end

  logic en;

  logic              s1_valid_q, s1_valid_d;
  logic              s1_sign_q, s1_sign_d;
  logic [BW_INT-1:0] s1_mag_q, s1_mag_d;

  logic              s2_valid_q, s2_valid_d;
  fix2real_norm_t    s2_q, s2_d;
  logic [LZW-1:0]    lz;
  logic [BW_INT-1:0] norm;

  logic              out_valid_q, out_valid_d;
  real_t             out_data_q, out_data_d;
  logic              inexact_d;

  logic                      lead;
  logic [BW_FRAC-1:0]        mant;
  logic                      guard;
  logic [REST_W-1:0]         rest;
  logic                      sticky;
  logic                      rnd_up;
  logic                      is_zero;
  logic [BW_FRAC:0]          mant_rnd;
  logic signed [BW_EXPS-1:0] expn_rnd;
  real_t                     res;
  logic                      unused_expn_hi;

  always_comb begin
    en       = !out_valid_q || out_ready;
    in_ready = en;
  end

  // S1: sign/magnitude; negating the most-negative value wraps to 2^(BW_INT-1).
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_sign_d  = s1_sign_q;
    s1_mag_d   = s1_mag_q;
    if (en) begin
      s1_valid_d = in_valid;
      s1_sign_d  = in_data[BW_INT-1];
      s1_mag_d   = in_data[BW_INT-1] ? (~in_data + BW_INT'(1)) : in_data;
    end
  end

  fpu_lzc #(.WIDTH(BW_INT)) u_lzc (
    .data  (s1_mag_q),
    .count (lz)
  );

  // S2: normalize and pre-compute the unrounded exponent.
  always_comb begin
    norm       = s1_mag_q << lz;
    s2_valid_d = s2_valid_q;
    s2_d       = s2_q;
    if (en) begin
      s2_valid_d = s1_valid_q;
      s2_d.sign  = s1_sign_q;
      s2_d.zero  = (s1_mag_q == '0);
      s2_d.expn  = EXP_TOP - $signed(BW_EXPS'(lz));
      s2_d.norm  = BW_INT_MAX'(norm) << (BW_INT_MAX - BW_INT);
    end
  end

  // S3: round to nearest even and pack. The exponent range is proven legal
  // at elaboration, so only its low BW_EXPN bits reach the output.
  always_comb begin
    {lead, mant, guard, rest} = s2_q.norm;
    sticky   = |rest;
    rnd_up   = guard && (sticky || mant[0]);
    mant_rnd = {1'b0, mant} + (BW_FRAC+1)'(rnd_up);
    expn_rnd = s2_q.expn + $signed({{(BW_EXPS-1){1'b0}}, mant_rnd[BW_FRAC]});
    unused_expn_hi = ^expn_rnd[BW_EXPS-1:BW_EXPN];
    is_zero  = s2_q.zero || !lead;
    res      = pack_real(s2_q.sign, expn_rnd[BW_EXPN-1:0], mant_rnd[BW_FRAC-1:0]);
    if (is_zero) res = '0;
    inexact_d = !is_zero && (guard || sticky);

    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    if (en) begin
      out_valid_d = s2_valid_q;
      out_data_d  = res;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_sign_q   <= 1'b0;
      s1_mag_q    <= '0;
      s2_valid_q  <= 1'b0;
      s2_q        <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sign_q   <= s1_sign_d;
      s1_mag_q    <= s1_mag_d;
      s2_valid_q  <= s2_valid_d;
      s2_q        <= s2_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

`ifdef FPU_FIX2REAL_STATUS_EN
  logic out_inexact_q, out_inexact_d;

  always_comb begin
    out_inexact_d = out_inexact_q;
    if (en) out_inexact_d = inexact_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) out_inexact_q <= 1'b0;
    else        out_inexact_q <= out_inexact_d;
  end

  assign out_inexact = out_inexact_q;
`else
  logic unused_inexact;
  assign unused_inexact = inexact_d;
`endif

endmodule

// File: tb/tb_fpu_fix2real.sv
// Directed bench for fpu_fix2real: vector table on FRAC_BITS=0 and 16
// instances, then backpressure and mid-stream reset sequences.
module tb_fpu_fix2real;
  import fpu_pack::*;

  logic clk;
  logic rst_n;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [31:0] a_in_data, a_out_data;
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [31:0] b_in_data, b_out_data;
`ifdef FPU_FIX2REAL_STATUS_EN
  logic        a_inexact, b_inexact;
`endif

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        f16;
    logic [31:0] din;
    logic [31:0] dout;
    logic        inx;
  } vec_t;

  vec_t        vecs[13];
  logic [31:0] bp_in[8];
  logic [31:0] bp_exp[8];

  fpu_fix2real #(.BW_INT(32), .FRAC_BITS(0)) dut_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .in_data   (a_in_data),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .out_data  (a_out_data)
`ifdef FPU_FIX2REAL_STATUS_EN
    ,
    .out_inexact (a_inexact)
`endif
  );

  fpu_fix2real #(.BW_INT(32), .FRAC_BITS(16)) dut_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .in_data   (b_in_data),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .out_data  (b_out_data)
`ifdef FPU_FIX2REAL_STATUS_EN
    ,
    .out_inexact (b_inexact)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated word through the selected instance; returns the first
  // valid output and the cycles it took (capped at 10).
  task automatic run_vec(input logic f16, input logic [31:0] din,
                         output logic [31:0] dout, output logic inx, output int lat);
    if (f16) begin b_in_valid = 1'b1; b_in_data = din; end
    else     begin a_in_valid = 1'b1; a_in_data = din; end
    step();
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
    lat = 1;
    while (!(f16 ? b_out_valid : a_out_valid) && lat < 10) begin
      step();
      lat++;
    end
    dout = f16 ? b_out_data : a_out_data;
`ifdef FPU_FIX2REAL_STATUS_EN
    inx = f16 ? b_inexact : a_inexact;
`else
    inx = 1'b0;
`endif
  endtask

  initial begin
    logic [31:0] dout;
    logic        inx;
    int          lat;
    int          sent;
    int          rcv;
    logic        stalled;
    logic [31:0] held;

    vecs[0]  = '{1'b0, 32'h0000_0001, 32'h3F80_0000, 1'b0};
    vecs[1]  = '{1'b0, 32'hFFFF_FFFF, 32'hBF80_0000, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b0, 32'h0100_0001, 32'h4B80_0000, 1'b1};
    vecs[4]  = '{1'b0, 32'h0100_0003, 32'h4B80_0002, 1'b1};
    vecs[5]  = '{1'b0, 32'h7FFF_FFFF, 32'h4F00_0000, 1'b1};
    vecs[6]  = '{1'b0, 32'h8000_0000, 32'hCF00_0000, 1'b0};
    vecs[7]  = '{1'b0, 32'h00FF_FFFF, 32'h4B7F_FFFF, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0003, 32'h4040_0000, 1'b0};
    vecs[9]  = '{1'b1, 32'h0001_8000, 32'h3FC0_0000, 1'b0};
    vecs[10] = '{1'b1, 32'hFFFF_0000, 32'hBF80_0000, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_0001, 32'h3780_0000, 1'b0};
    vecs[12] = '{1'b1, 32'h0000_0000, 32'h0000_0000, 1'b0};

    for (int i = 0; i < 8; i++) begin
      bp_in[i]  = vecs[i == 2 ? 8 : i].din;
      bp_exp[i] = vecs[i == 2 ? 8 : i].dout;
    end

    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
    repeat (3) step();
    chk("rst_a_out_valid", a_out_valid, 1'b0);
    chk("rst_a_out_data",  a_out_data,  32'h0);
    chk("rst_b_out_valid", b_out_valid, 1'b0);
    chk("rst_b_out_data",  b_out_data,  32'h0);
    rst_n = 1'b1;
    step();
    chk("rst_a_in_ready", a_in_ready, 1'b1);
    chk("rst_b_in_ready", b_in_ready, 1'b1);

    for (int i = 0; i < 13; i++) begin
      run_vec(vecs[i].f16, vecs[i].din, dout, inx, lat);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(LAT_FIX2REAL));
      chk($sformatf("vec%0d_data", i), dout, vecs[i].dout);
`ifdef FPU_FIX2REAL_STATUS_EN
      chk($sformatf("vec%0d_inexact", i), inx, vecs[i].inx);
`endif
      step();
    end

    // Backpressure: 8 back-to-back words, random out_ready.
    sent = 0;
    rcv = 0;
    stalled = 1'b0;
    held = '0;
    for (int cyc = 0; cyc < 300 && rcv < 8; cyc++) begin
      a_out_ready = 1'($urandom_range(0, 1));
      a_in_valid  = (sent < 8);
      a_in_data   = bp_in[sent < 8 ? sent : 0];
      #1;
      chk("bp_in_ready", a_in_ready, !a_out_valid || a_out_ready);
      if (stalled) begin
        chk("bp_hold_valid", a_out_valid, 1'b1);
        chk("bp_hold_data",  a_out_data,  held);
      end
      if (a_out_valid && a_out_ready) begin
        chk($sformatf("bp_word%0d", rcv), a_out_data, bp_exp[rcv]);
        rcv++;
      end
      stalled = a_out_valid && !a_out_ready;
      held    = a_out_data;
      if (a_in_valid && a_in_ready) sent++;
      @(posedge clk);
      #1;
    end
    chk("bp_received", 64'(rcv), 64'd8);
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("bp_no_dup", a_out_valid, 1'b0);
      step();
    end

    // Reset with three words in flight, while the output is also stalled.
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = bp_in[i];
      step();
    end
    a_in_valid = 1'b0;
    chk("mr_filled", a_out_valid, 1'b1);
    a_out_ready = 1'b0;
    rst_n = 1'b0;
    step();
    chk("mr_out_valid", a_out_valid, 1'b0);
    chk("mr_out_data",  a_out_data,  32'h0);
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mr_no_stale", a_out_valid, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
